// File: rtl/ntt_butterfly_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ntt_butterfly_pipe: pipelined CT/GS modular butterfly, valid/ready with backpressure, tag pass-through.
// Revision 1.0 - initial release.
module ntt_butterfly_pipe #(
  parameter int          WIDTH = 23,
  parameter int unsigned Q     = 8380417,
  parameter int          TAG_W = 8,
  parameter int          LAT   = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] twiddle_i,
  input  logic             sel_butterfly_i,
  input  logic             half_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] a_prime_o,
  output logic [WIDTH-1:0] b_prime_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam logic [WIDTH:0]     QX   = (WIDTH+1)'(Q);
  localparam logic [2*WIDTH-1:0] Q2   = (2*WIDTH)'(Q);
  localparam logic [2*WIDTH:0]   POW2 = {1'b1, {(2*WIDTH){1'b0}}};
  localparam logic [2*WIDTH:0]   MU_W = POW2 / (2*WIDTH+1)'(Q);
  localparam logic [2*WIDTH-1:0] MU   = MU_W[2*WIDTH-1:0];

  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= QX) ? WIDTH'(s - QX) : WIDTH'(s);
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return (x >= y) ? (x - y) : WIDTH'({1'b0, x} + QX - {1'b0, y});
  endfunction

  // Multiplication by 2^-1 mod Q: odd values are made even by adding Q first.
  function automatic logic [WIDTH-1:0] halve(input logic [WIDTH-1:0] x);
    return x[0] ? WIDTH'(({1'b0, x} + QX) >> 1) : (x >> 1);
  endfunction

  // Barrett with mu = floor(2^(2W)/Q); the estimate is short by at most one Q,
  // so a single conditional subtract gives an exact result for any x < 2^(2W).
  function automatic logic [WIDTH-1:0] reduce(input logic [2*WIDTH-1:0] x);
    logic [2*WIDTH-1:0] qe;
    logic [2*WIDTH-1:0] r;
    qe = (2*WIDTH)'(({{(2*WIDTH){1'b0}}, x} * {{(2*WIDTH){1'b0}}, MU}) >> (2*WIDTH));
    r  = x - qe * Q2;
    return (r >= Q2) ? WIDTH'(r - Q2) : WIDTH'(r);
  endfunction

  logic advance;
  logic accept;

  assign in_ready_o = !out_valid_o || out_ready_i;
  assign advance    = in_ready_o;
  assign accept     = in_valid_i && advance;

  // Stage 0: registered operands
  logic             s0_v;
  logic [WIDTH-1:0] s0_a, s0_b, s0_w;
  logic             s0_sel, s0_half;
  logic [TAG_W-1:0] s0_tag;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0_v    <= 1'b0;
      s0_a    <= '0;
      s0_b    <= '0;
      s0_w    <= '0;
      s0_sel  <= 1'b0;
      s0_half <= 1'b0;
      s0_tag  <= '0;
    end else if (advance) begin
      s0_v <= accept;
      if (accept) begin
        s0_a    <= a_i;
        s0_b    <= b_i;
        s0_w    <= twiddle_i;
        s0_sel  <= sel_butterfly_i;
        s0_half <= half_i;
        s0_tag  <= tag_i;
      end
    end
  end

  // Stage 1: add/sub and the exact 2W-bit product
  logic [WIDTH-1:0]   mul_op;
  logic [WIDTH-1:0]   pass_val;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    mul_op   = s0_sel ? sub_mod(s0_a, s0_b) : s0_b;
    pass_val = s0_sel ? add_mod(s0_a, s0_b) : s0_a;
    prod     = {{WIDTH{1'b0}}, mul_op} * {{WIDTH{1'b0}}, s0_w};
  end

  logic               s1_v;
  logic [2*WIDTH-1:0] s1_prod;
  logic [WIDTH-1:0]   s1_p;
  logic               s1_sel, s1_half;
  logic [TAG_W-1:0]   s1_tag;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v    <= 1'b0;
      s1_prod <= '0;
      s1_p    <= '0;
      s1_sel  <= 1'b0;
      s1_half <= 1'b0;
      s1_tag  <= '0;
    end else if (advance) begin
      s1_v <= s0_v;
      if (s0_v) begin
        s1_prod <= prod;
        s1_p    <= pass_val;
        s1_sel  <= s0_sel;
        s1_half <= s0_half;
        s1_tag  <= s0_tag;
      end
    end
  end

  // Stage 2: reduction and final combine
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] res_a, res_b;

  always_comb begin
    m = reduce(s1_prod);
    if (s1_sel) begin
      res_a = s1_half ? halve(s1_p) : s1_p;
      res_b = s1_half ? halve(m) : m;
    end else begin
      res_a = add_mod(s1_p, m);
      res_b = sub_mod(s1_p, m);
    end
  end

  // Stages 2..LAT: result stage followed by pure delay; stage LAT drives the outputs.
  logic             st_v   [2:LAT];
  logic [WIDTH-1:0] st_a   [2:LAT];
  logic [WIDTH-1:0] st_b   [2:LAT];
  logic [TAG_W-1:0] st_tag [2:LAT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 2; s <= LAT; s++) begin
        st_v[s]   <= 1'b0;
        st_a[s]   <= '0;
        st_b[s]   <= '0;
        st_tag[s] <= '0;
      end
    end else if (advance) begin
      st_v[2] <= s1_v;
      if (s1_v) begin
        st_a[2]   <= res_a;
        st_b[2]   <= res_b;
        st_tag[2] <= s1_tag;
      end
      for (int s = 3; s <= LAT; s++) begin
        st_v[s] <= st_v[s-1];
        if (st_v[s-1]) begin
          st_a[s]   <= st_a[s-1];
          st_b[s]   <= st_b[s-1];
          st_tag[s] <= st_tag[s-1];
        end
      end
    end
  end

  assign out_valid_o = st_v[LAT];
  assign a_prime_o   = st_a[LAT];
  assign b_prime_o   = st_b[LAT];
  assign tag_o       = st_tag[LAT];

endmodule
`default_nettype wire

// File: tb/tb_ntt_butterfly_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// tb_ntt_butterfly_pipe: randomized scoreboard bench with an arithmetic reference model.
// Revision 1.0 - initial release.
module tb_ntt_butterfly_pipe;
  localparam int              WIDTH = 23;
  localparam longint unsigned QM    = 64'd8380417;
  localparam int              TAG_W = 8;
  localparam int              LAT   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a_in, b_in, tw;
  logic             sel, half;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] a_out, b_out;
  logic [TAG_W-1:0] tag_out;

  ntt_butterfly_pipe #(.WIDTH(WIDTH), .Q(32'd8380417), .TAG_W(TAG_W), .LAT(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a_in), .b_i(b_in), .twiddle_i(tw),
    .sel_butterfly_i(sel), .half_i(half), .tag_i(tag_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .a_prime_o(a_out), .b_prime_o(b_out), .tag_o(tag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned ap;
    longint unsigned bp;
    logic [TAG_W-1:0] tag;
    int cyc;
    int stalls;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0, stall_cnt = 0;
  logic [TAG_W-1:0] next_tag = 8'h20;

  always @(negedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model(input longint unsigned a, input longint unsigned b, input longint unsigned w,
                                input logic s, input logic h,
                                output longint unsigned ap, output longint unsigned bp);
    longint unsigned t, inv2;
    inv2 = (QM + 1) / 2;
    if (!s) begin
      t  = (w * b) % QM;
      ap = (a + t) % QM;
      bp = (a + QM - t) % QM;
    end else begin
      ap = (a + b) % QM;
      bp = (((a + QM - b) % QM) * w) % QM;
      if (h) begin
        ap = (ap * inv2) % QM;
        bp = (bp * inv2) % QM;
      end
    end
  endfunction

  // Called at a falling edge; holds the operands until accepted.
  task automatic send(input longint unsigned a, input longint unsigned b, input longint unsigned w,
                      input logic s, input logic h, input logic [TAG_W-1:0] t,
                      input bit directed, input longint unsigned ea, input longint unsigned eb);
    exp_t e;
    int n;
    if (directed) begin
      e.ap = ea;
      e.bp = eb;
    end else begin
      model(a, b, w, s, h, e.ap, e.bp);
    end
    e.tag    = t;
    in_valid = 1'b1;
    a_in     = WIDTH'(a);
    b_in     = WIDTH'(b);
    tw       = WIDTH'(w);
    sel      = s;
    half     = h;
    tag_in   = t;
    n = 0;
    forever begin
      #3;
      if (in_ready && rst_n) begin
        e.cyc    = cyc;
        e.stalls = stall_cnt;
        sb.push_back(e);
        @(negedge clk);
        break;
      end
      @(negedge clk);
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: tag %0d not accepted within %0d cycles", t, n);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send($urandom_range(32'(QM - 1), 0), $urandom_range(32'(QM - 1), 0), $urandom_range(32'(QM - 1), 0),
         1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), next_tag, 1'b0, 0, 0);
    next_tag = next_tag + 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: samples just before each rising edge.
  initial begin
    logic             stalled;
    logic [WIDTH-1:0] pa, pb;
    logic [TAG_W-1:0] pt;
    exp_t             e;
    stalled = 1'b0;
    pa = '0; pb = '0; pt = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        chk("in_ready_rule", in_ready, (!out_valid || out_ready));
        if (stalled) begin
          chk("stall_valid_held", out_valid, 1);
          chk("stall_a_held", a_out, pa);
          chk("stall_b_held", b_out, pb);
          chk("stall_tag_held", tag_out, pt);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got tag %0d, expected no output", tag_out);
          end else begin
            e = sb.pop_front();
            chk("a_prime", a_out, e.ap);
            chk("b_prime", b_out, e.bp);
            chk("tag", tag_out, e.tag);
            chk("latency", cyc - e.cyc, LAT + 1 + (stall_cnt - e.stalls));
          end
        end
        if (out_valid && !out_ready) begin
          stall_cnt++;
          stalled = 1'b1;
          pa = a_out; pb = b_out; pt = tag_out;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; tw = '0;
    sel = 1'b0; half = 1'b0; tag_in = '0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_a_prime", a_out, 0);
    chk("reset_b_prime", b_out, 0);
    chk("reset_tag", tag_out, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1);

    // Directed arithmetic, including wrap cases
    send(1, 2, 3, 1'b0, 1'b0, 8'h11, 1'b1, 7, QM - 5);
    repeat (8) @(negedge clk);
    send(5, 3, 10, 1'b1, 1'b0, 8'h12, 1'b1, 8, 20);
    send(5, 3, 10, 1'b1, 1'b1, 8'h13, 1'b1, 4, 10);
    send(1, 0, 1, 1'b1, 1'b1, 8'h14, 1'b1, (QM + 1) / 2, (QM + 1) / 2);
    send(QM - 1, 1, 1, 1'b0, 1'b0, 8'h15, 1'b1, 0, QM - 2);
    send(0, 1, 1, 1'b1, 1'b0, 8'h16, 1'b1, 1, QM - 1);
    send(QM - 1, QM - 1, QM - 1, 1'b0, 1'b1, 8'h17, 1'b0, 0, 0);
    send(0, QM - 1, QM - 1, 1'b1, 1'b1, 8'h18, 1'b0, 0, 0);
    drain();

    // Back-to-back random stream
    repeat (20) send_rand();
    drain();

    // Backpressure: 6-cycle output stall mid-stream
    fork
      repeat (15) send_rand();
      begin
        repeat (6) @(negedge clk);
        out_ready = 1'b0;
        repeat (6) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Random downstream readiness
    fork
      repeat (30) send_rand();
      begin
        repeat (45) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(1, 0));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight, first one parked at the output
    out_ready = 1'b0;
    repeat (3) send_rand();
    repeat (4) @(negedge clk);
    chk("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_a_prime", a_out, 0);
    chk("midreset_b_prime", b_out, 0);
    chk("midreset_tag", tag_out, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ready_after_midreset", in_ready, 1);
    repeat (8) @(negedge clk);
    send(1, 2, 3, 1'b0, 1'b0, 8'h5A, 1'b1, 7, QM - 5);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
